// File: rtl/fetch_queue_stage.sv
// Fetch stage: PC register + word-addressed instruction memory feeding a FIFO fetch queue toward decode.
// Optional build macro FETCH_MISALIGN_CHECK_EN makes a misaligned redirect flush, flag and stall until realigned.
module fetch_queue_stage #(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     IMEM_DEPTH = 256,
  parameter int unsigned     FQ_DEPTH   = 4,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [XLEN-1:0]             PC_in,
  input  logic [1:0]                  PC_op,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic [31:0]                 Instruction_out,
  output logic [XLEN-1:0]             PC_out,
  output logic [$clog2(FQ_DEPTH):0]   fq_count,
  output logic                        misalign_err
);

  localparam int unsigned IDX_W = $clog2(IMEM_DEPTH);
  localparam int unsigned PTR_W = $clog2(FQ_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FQ_FULL = CNT_W'(FQ_DEPTH);

  typedef enum logic [1:0] {
    PC_INC      = 2'b00,
    PC_LOAD     = 2'b01,
    PC_HOLD     = 2'b10,
    PC_HOLD_ALT = 2'b11
  } pc_op_e;

  pc_op_e pc_op;
  assign pc_op = pc_op_e'(PC_op);

  // Instruction memory has no write port; contents are loaded from outside the block.
  logic [31:0] mem [IMEM_DEPTH];

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  pc_fifo_q    [FQ_DEPTH];
  logic [31:0]      instr_fifo_q [FQ_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [IDX_W-1:0] imem_idx;
  logic [31:0]      fetch_word;
  logic             redirect;
  logic             redirect_bad;
  logic             stalled;
  logic             deq;
  logic             enq;

  assign imem_idx   = fetch_pc_q[IDX_W+1:2];
  assign fetch_word = mem[imem_idx];

  assign redirect = (pc_op == PC_LOAD);
  assign deq      = out_valid && out_ready;
  // A dequeue frees a slot in the same cycle, so a full queue still streams at one per cycle.
  assign enq      = (pc_op == PC_INC) && !stalled && ((count_q != FQ_FULL) || deq);

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  assign redirect_bad = redirect && (PC_in[1:0] != 2'b00);
  assign stalled      = misalign_q;
  assign misalign_err = misalign_q;

  always_comb begin
    misalign_d = misalign_q;
    if (redirect) begin
      misalign_d = redirect_bad;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end
`else
  logic unused_pc_lsbs;

  assign unused_pc_lsbs = ^PC_in[1:0];
  assign redirect_bad   = 1'b0;
  assign stalled        = 1'b0;
  assign misalign_err   = 1'b0;
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (redirect) begin
      // Redirect wins over a simultaneous dequeue: the whole queue is discarded.
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      if (!redirect_bad) begin
        fetch_pc_d = {PC_in[XLEN-1:2], 2'b00};
      end
    end else begin
      if (deq) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (enq) begin
        wr_ptr_d   = wr_ptr_q + 1'b1;
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
      case ({enq, deq})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // NOTE: queue storage is not reset; count_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (enq) begin
      pc_fifo_q[wr_ptr_q]    <= fetch_pc_q;
      instr_fifo_q[wr_ptr_q] <= fetch_word;
    end
  end

  assign out_valid       = (count_q != '0);
  assign fq_count        = count_q;
  assign PC_out          = out_valid ? pc_fifo_q[rd_ptr_q]    : '0;
  assign Instruction_out = out_valid ? instr_fifo_q[rd_ptr_q] : '0;

endmodule
